// File: rtl/demux_1to8_regbank.sv
// Write-side register bank for the 8-to-1 datapath mux: one handshaked write stream
// fanned out into eight registers. Optional macro REG0_ZERO_EN hardwires register 0 to zero.
module demux_1to8_regbank #(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_sel,
    input  logic [1:0]       wr_op,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [7:0]       dirty,
    input  logic [7:0]       ack,
    output logic [7:0]       wr_count,
    output logic             fsm_state
);

    typedef enum logic {SWEEP = 1'b0, RUN = 1'b1} state_t;

    // Handshake: a write is accepted on a rising edge where wr_valid && wr_ready;
    // wr_sel/wr_op/wr_data are sampled on that edge, result visible the next cycle.

`ifdef REG0_ZERO_EN
    localparam logic [WIDTH-1:0] REG0_INIT = '0;
`else
    localparam logic [WIDTH-1:0] REG0_INIT = INIT_VALUE;
`endif

    state_t           state;
    logic [2:0]       sweep_idx;
    logic [WIDTH-1:0] regs [8];

    logic             accept;
    logic             wr_hit;
    logic [WIDTH-1:0] wr_val;
    logic [7:0]       set_mask;

    assign accept    = wr_valid && wr_ready;
    assign fsm_state = state;

    always_comb begin
        wr_hit = 1'b0;
        wr_val = regs[wr_sel];
        if (accept) begin
            case (wr_op)
                2'b00: begin wr_val = wr_data;                wr_hit = 1'b1; end
                2'b01: begin wr_val = regs[wr_sel] + wr_data; wr_hit = 1'b1; end
                2'b10: begin wr_val = '0;                     wr_hit = 1'b1; end
                default: wr_hit = 1'b0;
            endcase
        end
`ifdef REG0_ZERO_EN
        // Register 0 absorbs writes: still counted, but never changes or turns dirty.
        if (wr_sel == 3'd0) wr_hit = 1'b0;
`endif
        set_mask = wr_hit ? (8'b1 << wr_sel) : 8'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs[i] <= (i == 0) ? REG0_INIT : INIT_VALUE;
            dirty     <= 8'b0;
            wr_count  <= 8'b0;
            wr_ready  <= 1'b0;
            state     <= SWEEP;
            sweep_idx <= 3'd0;
        end else begin
            case (state)
                SWEEP: begin
                    regs[sweep_idx] <= (sweep_idx == 3'd0) ? REG0_INIT : INIT_VALUE;
                    sweep_idx       <= sweep_idx + 3'd1;
                    dirty           <= 8'b0;
                    if (sweep_idx == 3'd7) begin
                        state    <= RUN;
                        wr_ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (wr_hit) regs[wr_sel] <= wr_val;
                    // A set on the same edge as its ack takes priority.
                    dirty <= (dirty & ~ack) | set_mask;
                    if (accept) wr_count <= wr_count + 8'd1;
                end
                default: begin
                    state    <= SWEEP;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    assign out0 = regs[0];
    assign out1 = regs[1];
    assign out2 = regs[2];
    assign out3 = regs[3];
    assign out4 = regs[4];
    assign out5 = regs[5];
    assign out6 = regs[6];
    assign out7 = regs[7];

endmodule
